instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//   IF stage master for the word-addressed instruction memory: owns the PC, drives the
//   memory word address and captures the returned 32-bit instruction into the IF/ID register.
//   Handles decode-stage stall, branch/jump redirect (flush) and out-of-range PC faults.
//   Sits between the instruction memory and the ID stage of the 5-stage MIPS pipeline.
// PARAMETERS
//   ADDR_W    6             instruction memory word-address width (depth = 2**ADDR_W words)
//   RESET_PC  32'h0000_0000 byte PC loaded on reset
// PORTS
//   clk            in   1   rising-edge clock
//   reset          in   1   synchronous, active-high reset
//   imem_addr      out  ADDR_W  word address = pc[ADDR_W+1:2]; memory read is combinational
//   imem_rdata     in   32  instruction returned by memory in the same cycle
//   stall_d        in   1   ID not ready: hold PC and IF/ID contents
//   redirect_valid in   1   branch/jump taken in a later stage: flush and reload PC
//   redirect_pc    in   32  new byte PC; bits [1:0] ignored (forced to 0)
//   instr_d        out  32  IF/ID instruction
//   pc_d           out  32  IF/ID byte PC of instr_d
//   pcplus4_d      out  32  IF/ID pc_d + 4
//   valid_d        out  1   IF/ID holds a real instruction (0 = bubble)
//   fetch_fault    out  1   PC left memory range; fetch halted
//   fetch_count    out  32  instructions delivered to ID (valid_d && !stall_d cycles)
// BEHAVIOUR
//   - Reset: pc=RESET_PC, state=RUN, instr_d=0, pc_d=0, pcplus4_d=0, valid_d=0,
//     fetch_fault=0, fetch_count=0. First valid_d one cycle after reset deasserts.
//   - Latency: 1 cycle; instruction at PC p appears on instr_d/pc_d=p the cycle after
//     p is on imem_addr (with stall_d low).
//   - States: RUN, FAULT.
//     RUN, normal cycle (no stall, no redirect): IF/ID <= {imem_rdata, pc, pc+4, 1};
//       pc <= pc+4 (32-bit, wraps mod 2**32).
//     RUN, stall_d=1 and no redirect: pc and IF/ID hold; fetch_count holds.
//     RUN, pc >= 4*2**ADDR_W (out of range) and no redirect: valid_d <= 0, fetch_fault <= 1,
//       -> FAULT; PC holds; imem_addr still pc[ADDR_W+1:2] (value don't-care).
//     FAULT: valid_d=0, pc holds, fetch_fault=1 until redirect_valid.
//   - redirect_valid (either state) has priority over stall_d and fault: pc <= {redirect_pc[31:2],2'b00};
//     valid_d <= 0 (other IF/ID fields don't-care, implementation zeroes them);
//     fetch_fault <= 0; state <= RUN. If redirect_pc is itself out of range, FAULT is
//     re-entered on the following cycle.
//   - Stall with valid_d=0 is legal; nothing is delivered, bubble holds.
//   - fetch_count increments when valid_d && !stall_d (instruction accepted by ID),
//     independent of a same-cycle redirect; wraps at 2**32.
//   - Reset asserted mid-operation overrides everything in that cycle (all reset values).
// STRUCTURE
//   - mips_pkg: RESET_PC default, fetch_state_t enum {RUN, FAULT}, IMEM_ADDR_W constant,
//     if_id_t struct {instr, pc, pcplus4, valid}.
//   - One sub-module: if_id_reg (enable=!stall_d, sync clear=reset|flush) holding if_id_t;
//     PC register, next-PC mux, range check, FSM and counter live in instr_fetch.
// TESTING
//   1 Reset then free-run with memory[i]=32'h2000_0000+i: instr_d=32'h2000_0000,
//     pc_d=0, pcplus4_d=4 on cycle 1; consecutive words each cycle; fetch_count=5 after 5.
//   2 stall_d high 3 cycles while pc_d=8: instr_d/pc_d hold 8, imem_addr holds 3,
//     fetch_count frozen; resumes with pc_d=12.
//   3 redirect_valid with redirect_pc=32'h0000_0022 while stall_d=1: next cycle
//     valid_d=0, imem_addr=8; following cycle pc_d=32'h20, valid_d=1.
//   4 Free-run to pc=252 (ADDR_W=6): word 63 delivered, then pc=256 -> fetch_fault=1,
//     valid_d=0 held; redirect_pc=0 clears fault, pc_d=0 delivered next cycle.
//   5 Reset asserted mid-stream during stall and redirect: next cycle all outputs at
//     reset values, imem_addr=RESET_PC[ADDR_W+1:2].
//   6 Run with memory loaded from the unit-test .dat files: sequence of (pc_d, instr_d)
//     matches file contents in order until the first redirect.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction-fetch slice.
package mips_pkg;

  localparam int IMEM_ADDR_W = 6;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        valid;
  } if_id_t;

  // True when a byte PC addresses a word inside a 2**aw-word memory.
  function automatic logic pc_in_range(input logic [31:0] pc, input int aw);
    return (pc >> (aw + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: synchronous clear wins over the load enable.
module if_id_reg
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   clear,
  input  logic   enable,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t q_r;

  // Capture the fetched instruction bundle, or flush it to a bubble.
  always_ff @(posedge clk) begin
    if (clear) begin
      q_r <= '0;
    end else if (enable) begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/instr_fetch.sv
// IF stage: PC register, next-PC selection, range fault FSM, IF/ID register and delivery counter.
module instr_fetch
  import mips_pkg::*;
#(
  parameter int          ADDR_W   = IMEM_ADDR_W,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall_d,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       instr_d,
  output logic [31:0]       pc_d,
  output logic [31:0]       pcplus4_d,
  output logic              valid_d,
  output logic              fetch_fault,
  output logic [31:0]       fetch_count
);

  fetch_state_t state_r, state_next_s;
  logic [31:0]  pc_r, pc_next_s;
  logic         fault_r;
  logic [31:0]  count_r;
  logic         in_range_s;
  logic         ifid_en_s;
  if_id_t       ifid_d_s, ifid_q_s;

  assign in_range_s = pc_in_range(pc_r, ADDR_W);
  assign imem_addr  = pc_r[ADDR_W+1:2];

  // State, PC, fault flag and delivery counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RUN;
      pc_r    <= RESET_PC;
      fault_r <= 1'b0;
      count_r <= 32'd0;
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
      fault_r <= (state_next_s == FAULT);
      count_r <= count_r + {31'd0, (ifid_q_s.valid && !stall_d)};
    end
  end

  // Next-state: a stalled RUN cycle holds, so a fault is only taken when ID can move.
  always_comb begin
    state_next_s = state_r;
    if (redirect_valid) begin
      state_next_s = RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (!stall_d && !in_range_s) begin
            state_next_s = FAULT;
          end else begin
            state_next_s = RUN;
          end
        end
        FAULT:   state_next_s = FAULT;
        default: state_next_s = RUN;
      endcase
    end
  end

  // Next PC and IF/ID load value; a redirect is handled by the flush clear.
  always_comb begin
    pc_next_s = pc_r;
    ifid_en_s = !stall_d;
    ifid_d_s  = '{instr: imem_rdata, pc: pc_r, pcplus4: pc_r + 32'd4, valid: 1'b1};
    if (redirect_valid) begin
      pc_next_s = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      case (state_r)
        RUN: begin
          if (stall_d) begin
            pc_next_s = pc_r;
          end else if (!in_range_s) begin
            ifid_d_s = '0;
          end else begin
            pc_next_s = pc_r + 32'd4;
          end
        end
        FAULT:   ifid_d_s = '0;
        default: ifid_d_s = '0;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk    (clk),
    .clear  (reset | redirect_valid),
    .enable (ifid_en_s),
    .d      (ifid_d_s),
    .q      (ifid_q_s)
  );

  assign instr_d     = ifid_q_s.instr;
  assign pc_d        = ifid_q_s.pc;
  assign pcplus4_d   = ifid_q_s.pcplus4;
  assign valid_d     = ifid_q_s.valid;
  assign fetch_fault = fault_r;
  assign fetch_count = count_r;

endmodule
